// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its pick logic.
// The RX demux is expected to reuse these types as well.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HEADER,
        ARB_DATA
    } arb_state_t;

    // Widest source index the header byte can carry (HDR_BASE low nibble is free).
    localparam int SRC_IDX_W = 4;

    function automatic logic [7:0] hdr_byte(input logic [7:0] base,
                                            input logic [SRC_IDX_W-1:0] idx);
        return base + {{(8-SRC_IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last',
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int off = N; off >= 1; off--) begin
            cand = IW'((int'(last) + off) % N);
            if (req[cand]) winner = cand;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX stream between NUM_SRC
// AXI-stream sources; every packet is prefixed with a source header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_SRC    = 4,
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] HDR_BASE   = 8'hA0,
    parameter int         MAX_BEATS  = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          busy,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          overflow_err
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(MAX_BEATS + 1);

    arb_state_t                           state;
    logic [GW-1:0]                        last_grant;
    logic [BW-1:0]                        beat_cnt;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data;
    logic [GW-1:0]                        rr_winner;
    logic                                 rr_any;
    logic                                 beat;

    assign src_data = s_tdata;

    rr_pick #(.N(NUM_SRC), .IW(GW)) u_pick (
        .req     (s_tvalid),
        .last    (last_grant),
        .winner  (rr_winner),
        .any_req (rr_any)
    );

    assign beat = (state == ARB_DATA) && s_tvalid[grant_id] && m_tready;
    assign busy = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            last_grant   <= GW'(NUM_SRC - 1);
            grant_id     <= '0;
            beat_cnt     <= '0;
            overflow_err <= 1'b0;
        end else begin
            overflow_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (enable && rr_any) begin
                        grant_id <= rr_winner;
                        state    <= ARB_HEADER;
                    end
                end
                ARB_HEADER: begin
                    if (m_tready) begin
                        beat_cnt <= '0;
                        state    <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (s_tlast[grant_id]) begin
                            last_grant <= grant_id;
                            state      <= ARB_IDLE;
                        end else if (beat_cnt == BW'(MAX_BEATS - 1)) begin
                            // Runaway packet: release the path; leftovers re-arbitrate.
                            overflow_err <= 1'b1;
                            last_grant   <= grant_id;
                            state        <= ARB_IDLE;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Header is driven from registered grant_id, so it is stable under stall.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        case (state)
            ARB_HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = DATA_WIDTH'(hdr_byte(HDR_BASE, SRC_IDX_W'(grant_id)));
            end
            ARB_DATA: begin
                m_tvalid           = s_tvalid[grant_id];
                m_tdata            = src_data[grant_id];
                s_tready[grant_id] = m_tready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter: source queues feed the DUT,
// expected header/payload bytes are queued and popped on each output beat.
module tb_uart_tx_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;
    localparam int MB = 64;

    typedef struct packed { logic last; logic [7:0] d; } sbeat_t;
    typedef struct packed { logic hdr;  logic [7:0] d; } ebeat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b0;
    logic [NS*DW-1:0] s_tdata = '0;
    logic [NS-1:0]    s_tvalid = '0;
    logic [NS-1:0]    s_tlast = '0;
    logic [NS-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic             busy;
    logic [1:0]       grant_id;
    logic             overflow_err;

    uart_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .HDR_BASE(8'hA0), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .busy(busy), .grant_id(grant_id), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    sbeat_t      src_q[NS][$];
    ebeat_t      exp_q[$];
    logic [NS-1:0] fire = '0;
    logic        en_req = 1'b0;
    logic [3:0]  rdy_pat = 4'b1111;
    int          rdy_ph = 0;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_d = '0;
    int          pl_cnt = 0;
    int          ovf_n = 0;
    int          errs = 0;
    int          chks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int s, input int n, input int base);
        sbeat_t b;
        for (int k = 0; k < n; k++) begin
            b.last = (k == n - 1);
            b.d    = 8'(base + k);
            src_q[s].push_back(b);
        end
    endtask

    task automatic expect_seg(input int s, input int n, input int base);
        ebeat_t e;
        e.hdr = 1'b1;
        e.d   = 8'(32'hA0 + s);
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            e.hdr = 1'b0;
            e.d   = 8'(base + k);
            exp_q.push_back(e);
        end
    endtask

    // Applied just after the active edge: retire accepted beats, present next ones.
    task automatic drive();
        sbeat_t b;
        for (int i = 0; i < NS; i++) begin
            if (fire[i] && src_q[i].size() > 0) b = src_q[i].pop_front();
            fire[i] = 1'b0;
            if (src_q[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tlast[i]           = src_q[i][0].last;
                s_tdata[i*DW +: DW]  = src_q[i][0].d;
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tlast[i]           = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
            end
        end
        enable   = en_req;
        m_tready = rdy_pat[rdy_ph];
        rdy_ph   = (rdy_ph + 1) % 4;
    endtask

    // Sampled mid-cycle: the values here are what the next active edge will see.
    task automatic monitor();
        ebeat_t e;
        logic [NS-1:0] oh;
        oh = NS'(1) << grant_id;
        if (hold_pend) begin
            check("hold_valid", 32'(m_tvalid), 32'd1);
            check("hold_data", 32'(m_tdata), 32'(hold_d));
        end
        hold_pend = m_tvalid && !m_tready;
        hold_d    = m_tdata;
        check("sready_other", 32'(s_tready & ~oh), 32'd0);
        check("sready_no_mready", 32'(s_tready[grant_id] & ~m_tready), 32'd0);
        if (overflow_err) begin
            ovf_n++;
            check("ovf_beat_pos", 32'(pl_cnt), 32'(MB));
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(m_tdata), 32'h100);
            end else begin
                e = exp_q.pop_front();
                check(e.hdr ? "hdr_byte" : "payload_byte", 32'(m_tdata), 32'(e.d));
                pl_cnt = e.hdr ? 0 : pl_cnt + 1;
            end
        end
        for (int i = 0; i < NS; i++) fire[i] = s_tvalid[i] && s_tready[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic run_drain(input int budget);
        int n;
        logic pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < budget) begin
            step();
            n++;
            pend = (exp_q.size() != 0);
            for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) pend = 1'b1;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        step();
        check("idle_after_pkt", 32'(busy), 32'd0);
    endtask

    // Asynchronous reset assertion away from any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_overflow", 32'(overflow_err), 32'd0);
        exp_q.delete();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        s_tvalid  = '0;
        s_tlast   = '0;
        fire      = '0;
        hold_pend = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        #1;
        check("init_m_tvalid", 32'(m_tvalid), 32'd0);
        check("init_s_tready", 32'(s_tready), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_grant_id", 32'(grant_id), 32'd0);
        check("init_overflow", 32'(overflow_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        en_req = 1'b1;

        // Single source, unstalled sink.
        push_src(1, 3, 'h11 - 0);
        src_q[1].delete();
        begin
            sbeat_t b;
            b = '{last: 1'b0, d: 8'h11}; src_q[1].push_back(b);
            b = '{last: 1'b0, d: 8'h22}; src_q[1].push_back(b);
            b = '{last: 1'b1, d: 8'h33}; src_q[1].push_back(b);
            exp_q.push_back('{hdr: 1'b1, d: 8'hA1});
            exp_q.push_back('{hdr: 1'b0, d: 8'h11});
            exp_q.push_back('{hdr: 1'b0, d: 8'h22});
            exp_q.push_back('{hdr: 1'b0, d: 8'h33});
        end
        run_drain(50);
        check("t1_grant_id", 32'(grant_id), 32'd1);

        // Three contenders from reset, then source 0 again.
        do_reset();
        push_src(0, 2, 'h01);
        push_src(2, 2, 'h21);
        push_src(3, 2, 'h31);
        expect_seg(0, 2, 'h01);
        expect_seg(2, 2, 'h21);
        expect_seg(3, 2, 'h31);
        run_drain(100);
        check("t2_grant_after_rr", 32'(grant_id), 32'd3);
        push_src(0, 2, 'h05);
        expect_seg(0, 2, 'h05);
        run_drain(50);
        check("t2_grant_wrap", 32'(grant_id), 32'd0);

        // Sink backpressure through header and payload.
        rdy_pat = 4'b1001;
        rdy_ph  = 0;
        push_src(2, 3, 'h5A);
        expect_seg(2, 3, 'h5A);
        run_drain(100);
        check("t3_grant_id", 32'(grant_id), 32'd2);
        rdy_pat = 4'b1111;

        // Oversized packet gets split with a fresh header.
        push_src(3, 70, 'h00);
        expect_seg(3, MB, 'h00);
        expect_seg(3, 70 - MB, MB);
        run_drain(300);
        check("t4_ovf_pulses", 32'(ovf_n), 32'd1);
        check("t4_grant_id", 32'(grant_id), 32'd3);

        // Grants gated by enable; dropping it mid-packet is harmless.
        en_req = 1'b0;
        push_src(1, 3, 'h77);
        repeat (20) step();
        check("t5_no_grant_busy", 32'(busy), 32'd0);
        check("t5_no_grant_valid", 32'(m_tvalid), 32'd0);
        expect_seg(1, 3, 'h77);
        en_req = 1'b1;
        step();
        check("t5_en_edge_valid", 32'(m_tvalid), 32'd0);
        step();
        check("t5_hdr_valid", 32'(m_tvalid), 32'd1);
        check("t5_hdr_data", 32'(m_tdata), 32'hA1);
        en_req = 1'b0;
        run_drain(50);
        check("t5_grant_id", 32'(grant_id), 32'd1);
        en_req = 1'b1;

        // Reset mid-payload, then source 0 must win from the reset pointer.
        push_src(2, 5, 'h50);
        expect_seg(2, 5, 'h50);
        repeat (4) step();
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        do_reset();
        push_src(0, 2, 'hC0);
        push_src(2, 1, 'hD0);
        expect_seg(0, 2, 'hC0);
        expect_seg(2, 1, 'hD0);
        run_drain(100);
        check("t6_grant_id", 32'(grant_id), 32'd2);
        check("total_ovf_pulses", 32'(ovf_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
